// File: rtl/hub75_pkg.sv
// Shared types for the HUB75 BCM scheduler: FSM state encoding, the
// (row, plane) slot record and the slot-order advance rule.
package hub75_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRELOAD,
    ST_LATCH,
    ST_DISPLAY,
    ST_BLANK
  } bcm_state_t;

  // Fixed-width slot record, wide enough for any practical panel; modules
  // slice the low bits they need.
  localparam int SLOT_ROW_W   = 8;
  localparam int SLOT_PLANE_W = 4;

  typedef struct packed {
    logic [SLOT_ROW_W-1:0]   row;
    logic [SLOT_PLANE_W-1:0] plane;
  } slot_t;

  // Planes advance first; the row steps after the last plane and wraps
  // after the last scan row.
  function automatic slot_t next_slot(slot_t cur,
                                      logic [SLOT_ROW_W-1:0] last_row,
                                      logic [SLOT_PLANE_W-1:0] last_plane);
    slot_t n;
    n = cur;
    if (cur.plane == last_plane) begin
      n.plane = '0;
      n.row   = (cur.row == last_row) ? '0 : cur.row + 8'd1;
    end else begin
      n.plane = cur.plane + 4'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/hub75_bcm_slot_counter.sv
// Row/plane pointer for the slot currently being requested from the
// column shifter. Cleared to (0,0) while idle, stepped once per latch.
module hub75_bcm_slot_counter
  import hub75_pkg::*;
#(
  parameter int SCAN_ROWS_P = 32,
  parameter int BPP_P       = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_clear,
  input  logic                           i_advance,
  output logic [$clog2(SCAN_ROWS_P)-1:0] o_row,
  output logic [$clog2(BPP_P)-1:0]       o_plane,
  output logic                           o_first
);

  localparam logic [SLOT_ROW_W-1:0]   LAST_ROW   = SLOT_ROW_W'(SCAN_ROWS_P - 1);
  localparam logic [SLOT_PLANE_W-1:0] LAST_PLANE = SLOT_PLANE_W'(BPP_P - 1);

  slot_t slot_q;
  slot_t slot_d;

  // Next pointer: clear wins over advance.
  always_comb begin
    slot_d = slot_q;
    if (i_clear) begin
      slot_d = '0;
    end else if (i_advance) begin
      slot_d = next_slot(slot_q, LAST_ROW, LAST_PLANE);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign o_row   = slot_q.row[$clog2(SCAN_ROWS_P)-1:0];
  assign o_plane = slot_q.plane[$clog2(BPP_P)-1:0];
  assign o_first = (slot_q == '0);

endmodule

// File: rtl/hub75_bcm_scheduler.sv
// Handshaked HUB75 BCM scheduler: requests each (row, plane) slot from the
// column shifter, latches it, shows it for base<<plane cycles, then blanks.
// Optional macro HUB75_BCM_DIM_EN adds i_dim, which shortens the OE-low
// window inside each slot without changing slot timing.
module hub75_bcm_scheduler
  import hub75_pkg::*;
#(
  parameter int ROWS_P     = 64,
  parameter int SEGMENTS_P = 2,
  parameter int BPP_P      = 8,
  parameter int CNT_W_P    = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  i_en,
  input  logic [CNT_W_P-1:0]                    i_base_wait,
  input  logic [CNT_W_P-1:0]                    i_blank,
`ifdef HUB75_BCM_DIM_EN
  input  logic [7:0]                            i_dim,
`endif
  output logic                                  o_load_valid,
  input  logic                                  i_load_ready,
  output logic [$clog2(ROWS_P/SEGMENTS_P)-1:0]  o_load_row,
  output logic [$clog2(BPP_P)-1:0]              o_load_plane,
  output logic                                  o_lat,
  output logic                                  o_oe_n,
  output logic [$clog2(ROWS_P/SEGMENTS_P)-1:0]  o_row_sel,
  output logic                                  o_frame_start,
  output logic                                  o_stall
);

  localparam int SCAN_P    = ROWS_P / SEGMENTS_P;
  localparam int ROW_W_P   = $clog2(SCAN_P);
  localparam int PLANE_W_P = $clog2(BPP_P);
  localparam int DW_P      = CNT_W_P + BPP_P;

  bcm_state_t             state_q;
  logic                   oe_n_q, lat_q, valid_q, fs_q, stall_q, load_done_q;
  logic [ROW_W_P-1:0]     row_sel_q;
  logic [PLANE_W_P-1:0]   disp_plane_q;
  logic [DW_P-1:0]        cnt_q, on_q;
  logic [CNT_W_P-1:0]     bcnt_q, sh_base_q, sh_blank_q;
  logic [ROW_W_P-1:0]     ptr_row;
  logic [PLANE_W_P-1:0]   ptr_plane;
  logic                   ptr_first;
  logic [CNT_W_P-1:0]     eff_base;
  logic [DW_P-1:0]        w_lat, on_lat;
  logic                   hs, loaded, enter_latch, ptr_clear;
`ifdef HUB75_BCM_DIM_EN
  logic [7:0]             sh_dim_q, eff_dim;
  logic [DW_P+8:0]        dim_prod;
`endif

  assign ptr_clear = !i_en || (state_q == ST_IDLE);

  hub75_bcm_slot_counter #(
    .SCAN_ROWS_P (SCAN_P),
    .BPP_P       (BPP_P)
  ) u_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (ptr_clear),
    .i_advance (enter_latch),
    .o_row     (ptr_row),
    .o_plane   (ptr_plane),
    .o_first   (ptr_first)
  );

  // Slot timing for the slot being latched and the latch-entry condition.
  // During the (0,0) latch the live config is used since the shadow only
  // updates at the end of that cycle.
  always_comb begin
    eff_base = fs_q ? i_base_wait : sh_base_q;
    w_lat    = {{BPP_P{1'b0}}, eff_base} << disp_plane_q;
`ifdef HUB75_BCM_DIM_EN
    eff_dim  = fs_q ? i_dim : sh_dim_q;
    dim_prod = {9'b0, w_lat} * {{(DW_P + 1){1'b0}}, eff_dim} + {9'b0, w_lat};
    on_lat   = DW_P'(dim_prod >> 8);
`else
    on_lat   = w_lat;
`endif
    hs          = valid_q & i_load_ready;
    loaded      = load_done_q | hs;
    enter_latch = 1'b0;
    case (state_q)
      ST_PRELOAD: enter_latch = hs;
      ST_DISPLAY: enter_latch = (cnt_q == DW_P'(1)) && (sh_blank_q == '0) && loaded;
      ST_BLANK:   enter_latch = (bcnt_q < CNT_W_P'(2)) && loaded;
      default:    enter_latch = 1'b0;
    endcase
  end

  // Scheduler FSM with registered panel and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      oe_n_q       <= 1'b1;
      lat_q        <= 1'b0;
      valid_q      <= 1'b0;
      fs_q         <= 1'b0;
      stall_q      <= 1'b0;
      load_done_q  <= 1'b0;
      row_sel_q    <= '0;
      disp_plane_q <= '0;
      cnt_q        <= '0;
      on_q         <= '0;
      bcnt_q       <= '0;
      sh_base_q    <= '0;
      sh_blank_q   <= '0;
`ifdef HUB75_BCM_DIM_EN
      sh_dim_q     <= '0;
`endif
    end else if (!i_en) begin
      // Stop abandons any pending load; the shifter simply sees valid drop.
      state_q     <= ST_IDLE;
      oe_n_q      <= 1'b1;
      lat_q       <= 1'b0;
      valid_q     <= 1'b0;
      fs_q        <= 1'b0;
      stall_q     <= 1'b0;
      load_done_q <= 1'b0;
      row_sel_q   <= '0;
    end else begin
      lat_q <= 1'b0;
      fs_q  <= 1'b0;
      if (enter_latch) begin
        state_q      <= ST_LATCH;
        lat_q        <= 1'b1;
        oe_n_q       <= 1'b1;
        valid_q      <= 1'b0;
        stall_q      <= 1'b0;
        row_sel_q    <= ptr_row;
        disp_plane_q <= ptr_plane;
        fs_q         <= ptr_first;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_PRELOAD;
            valid_q <= 1'b1;
          end
          ST_PRELOAD: valid_q <= 1'b1;
          ST_LATCH: begin
            if (fs_q) begin
              sh_base_q  <= i_base_wait;
              sh_blank_q <= i_blank;
`ifdef HUB75_BCM_DIM_EN
              sh_dim_q   <= i_dim;
`endif
            end
            state_q     <= ST_DISPLAY;
            cnt_q       <= w_lat;
            on_q        <= on_lat;
            oe_n_q      <= (on_lat == '0);
            valid_q     <= 1'b1;
            load_done_q <= 1'b0;
          end
          ST_DISPLAY: begin
            if (hs) begin
              valid_q     <= 1'b0;
              load_done_q <= 1'b1;
            end
            if (on_q != '0) on_q <= on_q - DW_P'(1);
            oe_n_q <= !(on_q > DW_P'(1));
            if (cnt_q == DW_P'(1)) begin
              state_q <= ST_BLANK;
              oe_n_q  <= 1'b1;
              bcnt_q  <= sh_blank_q;
              stall_q <= (sh_blank_q == '0);
            end else begin
              cnt_q <= cnt_q - DW_P'(1);
            end
          end
          ST_BLANK: begin
            if (hs) begin
              valid_q     <= 1'b0;
              load_done_q <= 1'b1;
            end
            if (bcnt_q != '0) bcnt_q <= bcnt_q - CNT_W_P'(1);
            stall_q <= (bcnt_q < CNT_W_P'(2));
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_load_valid  = valid_q;
  assign o_load_row    = ptr_row;
  assign o_load_plane  = ptr_plane;
  assign o_lat         = lat_q;
  assign o_oe_n        = oe_n_q;
  assign o_row_sel     = row_sel_q;
  assign o_frame_start = fs_q;
  assign o_stall       = stall_q;

endmodule

// File: tb/tb_hub75_bcm_scheduler.sv
// Bench for hub75_bcm_scheduler: 8 rows / 2 segments / 3 planes.
// A slot-level model predicts each slot's OE-low length, period and stall
// count from the base/blank/dim config and the shifter's ready delay.
module tb_hub75_bcm_scheduler;

  localparam int ROWS = 8, SEG = 2, BPP = 3, CW = 16;
  localparam int SCAN = ROWS / SEG;
  localparam int FRAME = SCAN * BPP;

  logic clk = 1'b0;
  logic rst_n, i_en, i_load_ready;
  logic [CW-1:0] i_base_wait, i_blank;
`ifdef HUB75_BCM_DIM_EN
  logic [7:0] i_dim;
`endif
  logic o_load_valid, o_lat, o_oe_n, o_frame_start, o_stall;
  logic [1:0] o_load_row, o_load_plane, o_row_sel;

  hub75_bcm_scheduler #(
    .ROWS_P(ROWS), .SEGMENTS_P(SEG), .BPP_P(BPP), .CNT_W_P(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_en(i_en),
    .i_base_wait(i_base_wait), .i_blank(i_blank),
`ifdef HUB75_BCM_DIM_EN
    .i_dim(i_dim),
`endif
    .o_load_valid(o_load_valid), .i_load_ready(i_load_ready),
    .o_load_row(o_load_row), .o_load_plane(o_load_plane),
    .o_lat(o_lat), .o_oe_n(o_oe_n), .o_row_sel(o_row_sel),
    .o_frame_start(o_frame_start), .o_stall(o_stall)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  bit chk_en = 1'b0;
  int ready_delay = 0;
  int k = -1;
  int cyc, low_cnt, stall_cnt, cur_w, cur_on, cur_blank, cur_d;
  int m_base, m_blank, m_dim;
  int low_hist[0:63], per_hist[0:63], stall_hist[0:63], row_hist[0:63];

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int exp_on(int w, int dim);
`ifdef HUB75_BCM_DIM_EN
    return (w * (dim + 1)) >> 8;
`else
    return w;
`endif
  endfunction

  // Shifter model: ready asserts once valid has been high ready_delay cycles.
  initial begin
    int vcnt;
    vcnt = 0;
    i_load_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (ready_delay == 0) begin
        i_load_ready = 1'b1;
        vcnt = 0;
      end else if (o_load_valid) begin
        vcnt++;
        i_load_ready = (vcnt >= ready_delay);
      end else begin
        vcnt = 0;
        i_load_ready = 1'b0;
      end
    end
  end

  // Per-cycle compare against the slot-level model.
  always @(negedge clk) begin
    int nk, hv, eper, sp;
    if (chk_en) begin
      if (o_load_valid) begin
        nk = k + 1;
        check("load_row", o_load_row, (nk / BPP) % SCAN);
        check("load_plane", o_load_plane, nk % BPP);
      end
      if (o_frame_start && !o_lat) check("frame_start_without_lat", 1, 0);
      if (o_lat) begin
        if (k >= 0 && k < 64) begin
          hv = (cur_d == 0) ? 1 : cur_d;
          sp = cur_w + cur_blank;
          eper = ((sp > hv) ? sp : hv) + 1;
          check("slot_period", cyc + 1, eper);
          check("oe_low_len", low_cnt, cur_on);
          check("stall_len", stall_cnt, eper - 1 - sp);
          per_hist[k] = cyc + 1;
          low_hist[k] = low_cnt;
          stall_hist[k] = stall_cnt;
        end
        k++;
        check("row_sel", o_row_sel, (k / BPP) % SCAN);
        check("frame_start", o_frame_start, (k % FRAME) == 0);
        check("oe_at_lat", o_oe_n, 1);
        if (k < 64) row_hist[k] = o_row_sel;
        if ((k % FRAME) == 0) begin
          m_base = i_base_wait;
          m_blank = i_blank;
`ifdef HUB75_BCM_DIM_EN
          m_dim = i_dim;
`else
          m_dim = 255;
`endif
        end
        cur_w = m_base << (k % BPP);
        cur_on = exp_on(cur_w, m_dim);
        cur_blank = m_blank;
        cyc = 0;
        low_cnt = 0;
        stall_cnt = 0;
      end else if (k >= 0) begin
        cyc++;
        if (cyc == 1) cur_d = ready_delay;
        if (!o_oe_n) begin
          low_cnt++;
          check("oe_low_contiguous", cyc, low_cnt);
        end
        if (o_stall) begin
          stall_cnt++;
          check("oe_high_in_stall", o_oe_n, 1);
        end
      end
    end
  end

  task automatic wait_slot(int n);
    int t;
    t = 0;
    while (k < n && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (k < n) check("wait_slot_timeout", k, n);
  endtask

  // Stop, then restart from (0,0) with the current config and ready_delay=0.
  task automatic restart();
    i_en = 1'b0;
    chk_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    k = -1;
    ready_delay = 0;
    i_en = 1'b1;
    @(negedge clk);
    check("restart_valid", o_load_valid, 1);
    check("restart_load_row", o_load_row, 0);
    check("restart_load_plane", o_load_plane, 0);
    chk_en = 1'b1;
    @(negedge clk);
    check("restart_lat", o_lat, 1);
    check("restart_frame_start", o_frame_start, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst_n = 1'b0;
    i_en = 1'b0;
    i_base_wait = 16'd4;
    i_blank = 16'd2;
`ifdef HUB75_BCM_DIM_EN
    i_dim = 8'd255;
`endif
    repeat (3) @(negedge clk);
    check("rst_oe_n", o_oe_n, 1);
    check("rst_lat", o_lat, 0);
    check("rst_load_valid", o_load_valid, 0);
    check("rst_load_row", o_load_row, 0);
    check("rst_load_plane", o_load_plane, 0);
    check("rst_row_sel", o_row_sel, 0);
    check("rst_frame_start", o_frame_start, 0);
    check("rst_stall", o_stall, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_valid_low", o_load_valid, 0);
    chk_en = 1'b1;
    i_en = 1'b1;
    @(negedge clk);
    check("preload_valid", o_load_valid, 1);

    // Ready tied high, base 4, blank 2.
    wait_slot(24);
    check("lit_low0", low_hist[0], 4);
    check("lit_low1", low_hist[1], 8);
    check("lit_low2", low_hist[2], 16);
    check("lit_per0", per_hist[0], 7);
    check("lit_per2", per_hist[2], 19);
    check("lit_row3", row_hist[3], 1);
    check("lit_row11", row_hist[11], 3);
    check("lit_row12", row_hist[12], 0);

    // Base 4 -> 2 mid-frame; takes effect at slot 36.
    wait_slot(30);
    @(negedge clk);
    @(negedge clk);
    i_base_wait = 16'd2;
    wait_slot(40);
    check("lit_low33_old_base", low_hist[33], 4);
    check("lit_low36", low_hist[36], 2);
    check("lit_low37", low_hist[37], 4);
    check("lit_low38", low_hist[38], 8);

    // Shifter answers 10 cycles after each request.
    wait_slot(44);
    @(negedge clk);
    @(negedge clk);
    ready_delay = 10;
    wait_slot(49);
    check("lit_stall45", stall_hist[45], 6);
    check("lit_per45", per_hist[45], 11);
    check("lit_stall46", stall_hist[46], 4);
    check("lit_stall47", stall_hist[47], 0);

    // Stop during DISPLAY with a load pending.
    t = 0;
    while (!(o_load_valid && !o_oe_n) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("found_pending_display", o_load_valid && !o_oe_n, 1);
    i_en = 1'b0;
    chk_en = 1'b0;
    @(negedge clk);
    check("stop_oe_n", o_oe_n, 1);
    check("stop_valid", o_load_valid, 0);
    check("stop_row_sel", o_row_sel, 0);
    check("stop_lat", o_lat, 0);
    check("stop_stall", o_stall, 0);
    check("stop_load_row", o_load_row, 0);
    check("stop_load_plane", o_load_plane, 0);

    i_base_wait = 16'd4;
    i_blank = 16'd2;
`ifdef HUB75_BCM_DIM_EN
    i_dim = 8'd127;
`endif
    restart();
    wait_slot(4);
`ifdef HUB75_BCM_DIM_EN
    check("dim127_low0", low_hist[0], 2);
    check("dim127_low1", low_hist[1], 4);
    check("dim127_low2", low_hist[2], 8);
`else
    check("re_low0", low_hist[0], 4);
    check("re_low1", low_hist[1], 8);
    check("re_low2", low_hist[2], 16);
`endif
    check("re_per0", per_hist[0], 7);
    check("re_per1", per_hist[1], 11);
    check("re_per2", per_hist[2], 19);

`ifdef HUB75_BCM_DIM_EN
    i_dim = 8'd0;
    restart();
    wait_slot(4);
    check("dim0_low0", low_hist[0], 0);
    check("dim0_low2", low_hist[2], 0);
    check("dim0_per0", per_hist[0], 7);
    check("dim0_per2", per_hist[2], 19);
`endif

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
